// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester external memory bus arbiter.
package mem_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_WORD: return addr_lo != 2'b00;
      SIZE_HALF: return addr_lo[0];
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// External peripheral memory bus; the arbiter is the master, the memory the slave.
interface mem_bus_arbiter_if #(
  parameter int unsigned BUS_ADDR_W = 16
);
  logic                  O_BUS_EN;
  logic                  O_BUS_WE;
  logic [1:0]            O_BUS_SIZE;
  logic [BUS_ADDR_W-1:0] O_BUS_ADDR;
  logic [31:0]           O_BUS_WRITE_DATA;
  logic                  I_BUS_RDY;
  logic [31:0]           I_BUS_READ_DATA;

  modport master (
    output O_BUS_EN, O_BUS_WE, O_BUS_SIZE, O_BUS_ADDR, O_BUS_WRITE_DATA,
    input  I_BUS_RDY, I_BUS_READ_DATA
  );

  modport slave (
    input  O_BUS_EN, O_BUS_WE, O_BUS_SIZE, O_BUS_ADDR, O_BUS_WRITE_DATA,
    output I_BUS_RDY, I_BUS_READ_DATA
  );
endinterface

// File: rtl/mem_bus_watchdog.sv
// Per-transaction RDY watchdog: counts enabled cycles, flags the cycle whose edge reaches TIMEOUT.
module mem_bus_watchdog #(
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  logic [TO_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)       count_d = '0;
    else if (enable_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  // Asserted in the last allowed cycle so the bus drops exactly TIMEOUT cycles after it rose.
  assign expire_o = enable_i && (count_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and load/store, with
// fixed ls priority, fetch anti-starvation, request validation and an RDY watchdog.
module mem_bus_arbiter
  import mem_bus_arb_pkg::*;
#(
  parameter int unsigned BUS_ADDR_W    = 16,
  parameter int unsigned TIMEOUT       = 255,
  parameter int unsigned TO_W          = 8,
  parameter int unsigned LS_STREAK_MAX = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               if_req_i,
  input  logic [31:0]        if_addr_i,
  output logic               if_ack_o,
  output logic               if_err_o,
  output logic [31:0]        if_rdata_o,
  input  logic               ls_req_i,
  input  logic               ls_we_i,
  input  logic [1:0]         ls_size_i,
  input  logic [31:0]        ls_addr_i,
  input  logic [31:0]        ls_wdata_i,
  output logic               ls_ack_o,
  output logic               ls_err_o,
  output logic [31:0]        ls_rdata_o,
  mem_bus_arbiter_if.master  bus,
  output logic               busy_o
);

  localparam int unsigned STREAK_W = (LS_STREAK_MAX < 1) ? 1 : $clog2(LS_STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LS_STREAK_MAX);

  state_t                state_q, state_d;
  req_id_t               gnt_q, gnt_d;
  logic                  err_q, err_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic [BUS_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           if_rdata_q, if_rdata_d;
  logic [31:0]           ls_rdata_q, ls_rdata_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;

  logic        pick_ls;
  logic [31:0] cand_addr;
  logic [1:0]  cand_size;
  logic        cand_bad;
  logic        wd_expire;

  mem_bus_watchdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (state_q != BUS),
    .enable_i (state_q == BUS),
    .expire_o (wd_expire)
  );

  // Fetch wins a contest only once load/store has taken LS_STREAK_MAX grants in a row.
  assign pick_ls   = ls_req_i && !(if_req_i && (streak_q == STREAK_MAX));
  assign cand_addr = pick_ls ? ls_addr_i : if_addr_i;
  assign cand_size = pick_ls ? ls_size_i : SIZE_WORD;
  assign cand_bad  = (|cand_addr[31:BUS_ADDR_W]) || (cand_size == SIZE_RSVD) ||
                     misaligned(cand_size, cand_addr[1:0]);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    err_d      = err_q;
    we_d       = we_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    streak_d   = streak_q;
    case (state_q)
      IDLE: begin
        if (!if_req_i) streak_d = '0;
        if (ls_req_i || if_req_i) begin
          gnt_d = pick_ls ? REQ_LS : REQ_IF;
          if (!pick_ls)                                  streak_d = '0;
          else if (if_req_i && (streak_q != STREAK_MAX)) streak_d = streak_q + 1'b1;
          if (cand_bad) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            we_d    = pick_ls && ls_we_i;
            size_d  = cand_size;
            addr_d  = cand_addr[BUS_ADDR_W-1:0];
            wdata_d = pick_ls ? ls_wdata_i : '0;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (bus.I_BUS_RDY) begin
          err_d   = 1'b0;
          state_d = RESP;
          if (!we_q) begin
            if (gnt_q == REQ_LS) ls_rdata_d = bus.I_BUS_READ_DATA;
            else                 if_rdata_d = bus.I_BUS_READ_DATA;
          end
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      gnt_q      <= REQ_IF;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      streak_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      err_q      <= err_d;
      we_q       <= we_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      streak_q   <= streak_d;
    end
  end

  assign bus.O_BUS_EN         = (state_q == BUS);
  assign bus.O_BUS_WE         = (state_q == BUS) && we_q;
  assign bus.O_BUS_SIZE       = (state_q == BUS) ? size_q : '0;
  assign bus.O_BUS_ADDR       = (state_q == BUS) ? addr_q : '0;
  assign bus.O_BUS_WRITE_DATA = (state_q == BUS) ? wdata_q : '0;

  assign if_ack_o   = (state_q == RESP) && (gnt_q == REQ_IF) && !err_q;
  assign if_err_o   = (state_q == RESP) && (gnt_q == REQ_IF) &&  err_q;
  assign ls_ack_o   = (state_q == RESP) && (gnt_q == REQ_LS) && !err_q;
  assign ls_err_o   = (state_q == RESP) && (gnt_q == REQ_LS) &&  err_q;
  assign if_rdata_o = if_rdata_q;
  assign ls_rdata_o = ls_rdata_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a transaction-timeline reference model.
module tb_mem_bus_arbiter;
  import mem_bus_arb_pkg::*;

  localparam int unsigned AW   = 16;
  localparam int          TMO  = 5;
  localparam int          SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_ack, ls_err;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        busy;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.BUS_ADDR_W(AW)) bus ();

  mem_bus_arbiter #(
    .BUS_ADDR_W    (AW),
    .TIMEOUT       (TMO),
    .TO_W          (8),
    .LS_STREAK_MAX (SMAX)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_ack_o   (if_ack),
    .if_err_o   (if_err),
    .if_rdata_o (if_rdata),
    .ls_req_i   (ls_req),
    .ls_we_i    (ls_we),
    .ls_size_i  (ls_size),
    .ls_addr_i  (ls_addr),
    .ls_wdata_i (ls_wdata),
    .ls_ack_o   (ls_ack),
    .ls_err_o   (ls_err),
    .ls_rdata_o (ls_rdata),
    .bus        (bus),
    .busy_o     (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each grant is turned into a timeline of cycle numbers.
  int          cyc = 0;
  int          free_cyc = 0;
  int          g = -1, bs = -1, be = -1, rc = -1;
  int          streak = 0;
  int          m_delay = 0;
  int          blen;
  logic        m_ls = 1'b0, m_err = 1'b0, m_we = 1'b0, m_hit = 1'b0;
  logic [1:0]  m_size = '0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata_val = '0;
  logic [31:0] exp_if_rdata = '0, exp_ls_rdata = '0;
  logic        pick, bad;
  logic [31:0] ca;
  logic [1:0]  cs;
  logic        gq[$];

  int          rdy_delay = 0;
  logic [31:0] rdy_data = '0;
  logic        noise_rdy = 1'b0;
  logic        chk_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      free_cyc = 0; g = -1; bs = -1; be = -1; rc = -1; streak = 0;
      exp_if_rdata = '0; exp_ls_rdata = '0;
    end else begin
      if (cyc == be && m_hit && !m_we) begin
        if (m_ls) exp_ls_rdata = m_rdata_val;
        else      exp_if_rdata = m_rdata_val;
      end
      if (cyc >= free_cyc) begin
        pick = ls_req && !(if_req && streak == SMAX);
        if (ls_req || if_req) begin
          gq.push_back(pick);
          ca  = pick ? ls_addr : if_addr;
          cs  = pick ? ls_size : 2'b10;
          bad = ((ca >> AW) != 0) || (cs == 2'b11) ||
                (cs == 2'b10 && (ca % 4) != 0) || (cs == 2'b01 && (ca % 2) != 0);
          g = cyc; m_ls = pick; m_we = pick && ls_we; m_size = cs; m_addr = ca;
          m_wdata = pick ? ls_wdata : '0; m_delay = rdy_delay; m_rdata_val = rdy_data;
          if (bad) begin
            bs = -1; be = -1; rc = cyc + 1; m_err = 1'b1; m_hit = 1'b0;
          end else begin
            blen  = (m_delay + 1 < TMO) ? m_delay + 1 : TMO;
            m_hit = (m_delay + 1 <= TMO);
            bs = cyc + 1; be = cyc + blen; rc = be + 1; m_err = !m_hit;
          end
          free_cyc = rc + 1;
        end
        if (!if_req)                     streak = 0;
        else if (!pick)                  streak = 0;
        else if (streak < SMAX)          streak++;
      end
    end
    cyc++;
  end

  // Memory responder follows the model's timeline, not the DUT.
  always @(negedge clk) begin
    bus.I_BUS_RDY       = noise_rdy || (!rst && bs >= 0 && cyc == bs + m_delay && cyc <= be);
    bus.I_BUS_READ_DATA = noise_rdy ? 32'hBAD0_BAD0 : m_rdata_val;
  end

  int   en_cnt = 0, if_ack_cnt = 0, ls_ack_cnt = 0, if_err_cnt = 0, ls_err_cnt = 0;
  logic x_en, x_resp;

  always @(negedge clk) begin
    if (chk_on) begin
      x_en   = !rst && bs >= 0 && cyc >= bs && cyc <= be;
      x_resp = !rst && rc >= 0 && cyc == rc;
      chk("bus_en",    32'(bus.O_BUS_EN),         32'(x_en));
      chk("bus_we",    32'(bus.O_BUS_WE),         32'(x_en && m_we));
      chk("bus_size",  32'(bus.O_BUS_SIZE),       x_en ? 32'(m_size) : 32'd0);
      chk("bus_addr",  32'(bus.O_BUS_ADDR),       x_en ? 32'(m_addr[AW-1:0]) : 32'd0);
      chk("bus_wdata", bus.O_BUS_WRITE_DATA,      x_en ? m_wdata : 32'd0);
      chk("if_ack",    32'(if_ack),               32'(x_resp && !m_ls && !m_err));
      chk("if_err",    32'(if_err),               32'(x_resp && !m_ls &&  m_err));
      chk("ls_ack",    32'(ls_ack),               32'(x_resp &&  m_ls && !m_err));
      chk("ls_err",    32'(ls_err),               32'(x_resp &&  m_ls &&  m_err));
      chk("if_rdata",  if_rdata,                  rst ? 32'd0 : exp_if_rdata);
      chk("ls_rdata",  ls_rdata,                  rst ? 32'd0 : exp_ls_rdata);
      chk("busy",      32'(busy),                 32'(!rst && g >= 0 && cyc > g && cyc < free_cyc));
    end
    if (bus.O_BUS_EN) en_cnt++;
    if (if_ack) if_ack_cnt++;
    if (ls_ack) ls_ack_cnt++;
    if (if_err) if_err_cnt++;
    if (ls_err) ls_err_cnt++;
  end

  task automatic wait_resp(input logic is_ls, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (is_ls ? (ls_ack || ls_err) : (if_ack || if_err)) begin
        lat = i + 1;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL resp_wait: no ack/err within 40 cycles, required one");
    end
  endtask

  task automatic txn(input logic is_ls, input logic we, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, input int dly,
                     input logic [31:0] rd, output int lat);
    rdy_delay = dly;
    rdy_data  = rd;
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    wait_resp(is_ls, lat);
    if (is_ls) ls_req = 1'b0;
    else       if_req = 1'b0;
    @(negedge clk);
  endtask

  int   lat, e0, a0, a1, r0, r1, acks;
  logic pat[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
    bus.I_BUS_RDY = 1'b0; bus.I_BUS_READ_DATA = '0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_en", 32'(bus.O_BUS_EN), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fetch, RDY on the third bus cycle.
    e0 = en_cnt; a0 = if_ack_cnt;
    txn(1'b0, 1'b0, 2'b10, 32'h0000_0010, '0, 2, 32'hDEAD_BEEF, lat);
    chk("t1_en_cycles", 32'(en_cnt - e0), 32'd3);
    chk("t1_ack_count", 32'(if_ack_cnt - a0), 32'd1);
    chk("t1_if_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("t1_latency", 32'(lat), 32'd4);

    // Byte store, RDY immediate.
    e0 = en_cnt;
    txn(1'b1, 1'b1, 2'b00, 32'h0000_1003, 32'h0000_00AB, 0, 32'h5555_5555, lat);
    chk("t2_en_cycles", 32'(en_cnt - e0), 32'd1);
    chk("t2_latency", 32'(lat), 32'd2);
    chk("t2_ls_rdata", ls_rdata, 32'd0);

    // Loads.
    txn(1'b1, 1'b0, 2'b10, 32'h0000_0020, '0, 1, 32'h1234_5678, lat);
    chk("t3_ls_rdata_word", ls_rdata, 32'h1234_5678);
    txn(1'b1, 1'b0, 2'b01, 32'h0000_0006, '0, 0, 32'h0000_CAFE, lat);
    chk("t3_ls_rdata_half", ls_rdata, 32'h0000_CAFE);

    // Both requesters held high.
    gq.delete();
    a0 = if_ack_cnt; a1 = ls_ack_cnt; acks = 0;
    rdy_delay = 0; rdy_data = 32'h1111_2222;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h0000_0040;
    if_req = 1'b1; if_addr = 32'h0000_0080;
    for (int i = 0; i < 60 && acks < 7; i++) begin
      @(negedge clk);
      if (ls_ack || if_ack) acks++;
    end
    ls_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("t4_acks", 32'(acks), 32'd7);
    chk("t4_grants", 32'(gq.size()), 32'd7);
    for (int k = 0; k < 7 && k < gq.size(); k++) chk($sformatf("t4_grant_%0d", k), 32'(gq[k]), 32'(pat[k]));
    chk("t4_if_acks", 32'(if_ack_cnt - a0), 32'd1);
    chk("t4_ls_acks", 32'(ls_ack_cnt - a1), 32'd6);

    // Invalid requests never reach the bus.
    e0 = en_cnt; r0 = ls_err_cnt; r1 = if_err_cnt;
    txn(1'b1, 1'b0, 2'b10, 32'h0001_0000, '0, 0, '0, lat);
    chk("t5_latency", 32'(lat), 32'd1);
    txn(1'b1, 1'b0, 2'b10, 32'h0000_0002, '0, 0, '0, lat);
    txn(1'b1, 1'b1, 2'b11, 32'h0000_0008, '0, 0, '0, lat);
    txn(1'b1, 1'b0, 2'b01, 32'h0000_0005, '0, 0, '0, lat);
    txn(1'b0, 1'b0, 2'b10, 32'h0000_0003, '0, 0, '0, lat);
    chk("t5_ls_errs", 32'(ls_err_cnt - r0), 32'd4);
    chk("t5_if_errs", 32'(if_err_cnt - r1), 32'd1);
    chk("t5_no_bus", 32'(en_cnt - e0), 32'd0);

    // Watchdog timeout, then stray RDY while idle.
    e0 = en_cnt; r0 = ls_err_cnt; a1 = ls_ack_cnt; a0 = if_ack_cnt;
    txn(1'b1, 1'b0, 2'b10, 32'h0000_0100, '0, 100, 32'h7777_7777, lat);
    chk("t6_en_cycles", 32'(en_cnt - e0), 32'd5);
    chk("t6_err", 32'(ls_err_cnt - r0), 32'd1);
    noise_rdy = 1'b1;
    repeat (3) @(negedge clk);
    noise_rdy = 1'b0;
    @(negedge clk);
    chk("t6_no_stray_ack", 32'(ls_ack_cnt - a1 + if_ack_cnt - a0), 32'd0);
    chk("t6_ls_rdata_kept", ls_rdata, 32'h1111_2222);

    // Reset during BUS.
    rdy_delay = 10; rdy_data = 32'h9999_9999;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h0000_0200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.O_BUS_EN) break;
    end
    @(negedge clk);
    a0 = if_ack_cnt + if_err_cnt; a1 = ls_ack_cnt + ls_err_cnt;
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_en", 32'(bus.O_BUS_EN), 32'd0);
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chk("t7_rst_if_rdata", if_rdata, 32'd0);
    chk("t7_rst_ls_rdata", ls_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0; ls_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("t7_no_resp_after_rst", 32'(if_ack_cnt + if_err_cnt - a0 + ls_ack_cnt + ls_err_cnt - a1), 32'd0);
    txn(1'b0, 1'b0, 2'b10, 32'h0000_0030, '0, 0, 32'h0BAD_F00D, lat);
    chk("t7_fetch_after_rst", if_rdata, 32'h0BAD_F00D);
    chk("t7_latency", 32'(lat), 32'd2);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++; n_fail++;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus (EN/WE/SIZE/ADDR/WDATA/RDY/RDATA) between two requesters: instruction fetch and load/store.
- Sits between the core-side memory controller paths and the external peripheral memory.
- Provides fixed load/store priority with a fetch anti-starvation limit, request validation, a per-transaction RDY watchdog, and a one-cycle ack/err response per requester.

Parameters:
- BUS_ADDR_W, 16, external bus address width; request address bits above this must be zero.
- TIMEOUT, 255, max cycles in BUS waiting for I_BUS_RDY before abort; legal range 1..2^TO_W-1.
- TO_W, 8, watchdog counter width.
- LS_STREAK_MAX, 4, consecutive contested load/store grants before fetch is forced.

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request; held with stable address until ack/err
- if_addr_i  in  32  fetch address; size is always word
- if_ack_o  out  1  one-cycle pulse: fetch completed, if_rdata_o valid
- if_err_o  out  1  one-cycle pulse: fetch rejected or timed out
- if_rdata_o  out  32  fetched word; held until next fetch capture
- ls_req_i  in  1  load/store request; held stable until ack/err
- ls_we_i  in  1  1 = store, 0 = load
- ls_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
- ls_addr_i  in  32  load/store address
- ls_wdata_i  in  32  store data
- ls_ack_o  out  1  one-cycle completion pulse
- ls_err_o  out  1  one-cycle error pulse
- ls_rdata_o  out  32  load data; held until next load capture
- O_BUS_EN  out  1  bus transaction active
- O_BUS_WE  out  1  write strobe, valid while O_BUS_EN
- O_BUS_SIZE  out  2  access size
- O_BUS_ADDR  out  BUS_ADDR_W  address
- O_BUS_WRITE_DATA  out  32  store data
- I_BUS_RDY  in  1  slave completion
- I_BUS_READ_DATA  in  32  read data, sampled when I_BUS_RDY=1
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0; rdata registers 0; FSM IDLE; streak 0; watchdog 0. Reset mid-transaction aborts immediately; no ack or err is issued afterwards.
- States: IDLE, BUS, RESP.
- IDLE, arbitration:
  - Sample requests.
  - ls wins a contest unless streak == LS_STREAK_MAX, in which case fetch wins.
  - streak +1, saturating, on an ls grant while if_req_i=1.
  - streak clears on any fetch grant, and whenever if_req_i=0 in IDLE.
- Validation, in the grant cycle:
  - Error if address bits [31:BUS_ADDR_W] are nonzero.
  - Error if size is 11.
  - Error if word access has addr[1:0] != 0, or half access has addr[0] != 0.
  - On error: no bus cycle, go to RESP with err set.
  - Otherwise register addr[BUS_ADDR_W-1:0], size, we, wdata and go to BUS. Fetch always uses WE=0, SIZE=10.
- BUS:
  - O_BUS_EN=1 and bus fields constant for the whole state.
  - The watchdog counts each cycle.
  - I_BUS_RDY=1: capture I_BUS_READ_DATA into the granted requester's rdata (loads and fetches only), go to RESP with ack.
  - Watchdog reaching TIMEOUT without RDY: go to RESP with err. O_BUS_EN drops on that edge.
  - RDY and timeout in the same cycle: RDY wins.
- RESP: exactly one of ack/err pulses for the granted requester, EN=0, requests ignored; go to IDLE next edge.
- Requester rules: drop req in the ack/err cycle or re-present a new request. Arbitration occurs only in IDLE.
- Best-case latency: req high in cycle 0 → EN in cycle 1 → RDY in cycle 1 → ack in cycle 2 → next grant at edge 3.
- I_BUS_RDY outside BUS is ignored.

Decomposition:
- Package mem_bus_arb_pkg holds:
  - state enum (IDLE/BUS/RESP)
  - size constants SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10
  - requester-id encoding REQ_IF / REQ_LS
- One sub-module, mem_bus_watchdog: a TO_W-bit counter with clear/enable inputs and an expire output at TIMEOUT.

Test Plan:
- Fetch only, if_addr_i=0x0000_0010, RDY after 3 cycles with data 0xDEADBEEF → O_BUS_ADDR=0x0010, SIZE=10, WE=0 for 3 cycles; if_ack_o pulses once; if_rdata_o=0xDEADBEEF.
- Store byte, addr 0x0000_1003, wdata 0x000000AB, RDY immediate → EN/WE high 1 cycle, SIZE=00; ls_ack_o at cycle 2; ls_rdata_o unchanged.
- Both requesters held high continuously, LS_STREAK_MAX=4, RDY immediate → grant order LS,LS,LS,LS,IF,LS,... ; streak clears after the IF grant.
- Invalid requests: ls_addr_i=0x0001_0000; word at 0x0002; size 11 → ls_err_o pulse each, O_BUS_EN never asserted.
- RDY held low, TIMEOUT=5 → EN high exactly 5 cycles, then err pulse, then IDLE; a later RDY=1 is ignored.
- rst_i asserted during BUS → all outputs 0 asynchronously; no ack/err after release; the next request is served normally.
